pc_branch_unit: RTL
===================

# pc_branch_unit

Parametrised program-counter unit with a run-time-writable branch-target table. It generalises the fixed 4-entry relative target lookup: it holds the PC register, provides 2**A programmable entries (each relative or absolute), advances the PC every cycle and detects the "hold" branch as a sticky halt. It sits between the instruction decoder (branch requests, table writes) and instruction memory (PC address).

## Interface
- D, 12, PC and target width in bits
- A, 4, table select width; DEPTH = 2**A entries
- START_PC, 0, PC value loaded on reset
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- stall  input  1  freeze PC and halt logic this cycle
- branch_en  input  1  take branch via entry tgt_sel this cycle
- tgt_sel  input  A  table entry used for the branch
- wr_en  input  1  write one table entry
- wr_addr  input  A  entry to write
- wr_mode  input  1  0 = relative offset, 1 = absolute target
- wr_data  input  D  offset (two's complement) or absolute PC
- pc  output  D  current PC (registered)
- halted  output  1  sticky: a branch resolved to the unchanged PC

## Operation
- Table: DEPTH entries of {mode, value[D-1:0]}, held in flops.
- Reset contents: entry 0 = rel −5 (0xFFB for D=12); entry 1 = rel +20; entry 2 = rel −1 (all ones); every other entry = rel 0 (hold).
- Write: on a clock edge with wr_en=1, entry wr_addr ← {wr_mode, wr_data}. Writes are accepted regardless of stall and halted.
- Effective entry for a branch: if wr_en=1 and wr_addr==tgt_sel in the same cycle, the incoming write data/mode is used (write-first bypass); otherwise the stored entry.
- Next PC, evaluated each edge, priority top-down:
  - halted=1 -> pc unchanged.
  - stall=1 -> pc unchanged; branch_en ignored (decoder must hold the request).
  - branch_en=1, mode 0 -> pc ← (pc + value) mod 2**D.
  - branch_en=1, mode 1 -> pc ← value.
  - otherwise -> pc ← (pc + 1) mod 2**D.
- Halt detect: when a branch is taken (not stalled, not halted) and the computed next PC equals the current pc (rel 0, or absolute equal to pc), halted ← 1 at that edge. Only reset clears halted.
- Arithmetic: D-bit add, carry discarded; no sign extension beyond D bits. Wrap-around at 2**D−1 → 0 is legal in both directions.

## Timing
- Reset (rst_n low, asynchronous, no clock needed): pc = START_PC, halted = 0, table = reset contents. Reset asserted mid-operation discards any in-flight write or branch. Deassertion is synchronised externally; first update occurs on the first rising edge with rst_n high.
- Latency: branch or increment visible on pc one edge after request; table write visible to later lookups one edge after wr_en; same-cycle write+branch to same entry uses new data (zero-cycle bypass).
- Write and branch to different entries in the same cycle: branch uses the stored (old) contents of tgt_sel.
- halted rises on the same edge that would have loaded the unchanged PC; pc therefore stays at that value.
- No combinational path from inputs to outputs.

## Test plan
- Reset, then 4 free-running cycles -> pc = 0x000, 0x001, 0x002, 0x003, 0x004; halted = 0.
- At pc = 0x004 branch tgt_sel=0 -> pc = 0xFFF; next cycle no branch -> pc wraps to 0x000. At pc = 0x000 branch sel 1 -> 0x014.
- Same cycle: wr_en, wr_addr=3, wr_mode=1, wr_data=0x123 and branch_en, tgt_sel=3 -> pc = 0x123 next edge; later branch sel 3 from pc 0x200 -> 0x123 again.
- stall=1 with branch_en=1, tgt_sel=2 at pc = 0x050 for 3 cycles -> pc stays 0x050; stall drops -> pc = 0x04F.
- At pc = 0x010 branch tgt_sel=5 (rel 0) -> pc stays 0x010, halted = 1; next 3 cycles of branches/increments -> pc frozen at 0x010, halted stays 1.
- Pull rst_n low between edges after the previous tests -> pc = 0x000 and halted = 0 immediately; branch sel 3 -> pc = 0x000, halted = 1 (entry 3 back to rel 0).

Source files
------------

// File: rtl/pc_branch_unit.sv
// Program counter with a run-time-writable branch-target table (relative or absolute entries)
// and a sticky halt raised when a taken branch resolves to the current PC.
module pc_branch_unit #(
    parameter int            D        = 12,
    parameter int            A        = 4,
    parameter logic [D-1:0]  START_PC = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         stall,
    input  logic         branch_en,
    input  logic [A-1:0] tgt_sel,
    input  logic         wr_en,
    input  logic [A-1:0] wr_addr,
    input  logic         wr_mode,
    input  logic [D-1:0] wr_data,
    output logic [D-1:0] pc,
    output logic         halted
);
    localparam int DEPTH = 1 << A;

    logic [DEPTH-1:0][D-1:0] tbl_val_q;
    logic [DEPTH-1:0]        tbl_mode_q;
    logic [D-1:0]            pc_q, pc_d;
    logic                    halted_q, halted_d;
    logic [D-1:0]            eff_val, br_tgt;
    logic                    eff_mode;

    // Entries 0..2 come up as rel -5, +20, -1; the rest are rel 0 (hold).
    function automatic logic [D-1:0] rst_val(input int i);
        if (i == 0) return D'(-5);
        if (i == 1) return D'(20);
        if (i == 2) return '1;
        return '0;
    endfunction

    always_comb begin
        eff_mode = tbl_mode_q[tgt_sel];
        eff_val  = tbl_val_q[tgt_sel];
        if (wr_en && (wr_addr == tgt_sel)) begin
            eff_mode = wr_mode;
            eff_val  = wr_data;
        end
        br_tgt   = eff_mode ? eff_val : (pc_q + eff_val);

        pc_d     = pc_q;
        halted_d = halted_q;
        if (!halted_q && !stall) begin
            if (branch_en) begin
                pc_d = br_tgt;
                if (br_tgt == pc_q) halted_d = 1'b1;
            end else begin
                pc_d = pc_q + D'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q     <= START_PC;
            halted_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                tbl_val_q[i]  <= rst_val(i);
                tbl_mode_q[i] <= 1'b0;
            end
        end else begin
            pc_q     <= pc_d;
            halted_q <= halted_d;
            // Table writes ignore stall and halt so the decoder can always reprogram.
            if (wr_en) begin
                tbl_val_q[wr_addr]  <= wr_data;
                tbl_mode_q[wr_addr] <= wr_mode;
            end
        end
    end

    assign pc     = pc_q;
    assign halted = halted_q;
endmodule
